// File: rtl/fifo_datapath.sv
// fifo_datapath: 8-entry FIFO storage, pointers, occupancy count and handshake status,
// sequenced by an externally supplied next-state code. Optional macro FIFO_STICKY_ERR_EN.
module fifo_datapath #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            next_state,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [2:0]            state,
  output logic [3:0]            data_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 8;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100,
    NO_OP    = 3'b101
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [2:0]            head;
  logic [2:0]            tail;
  state_t                state_q;
  state_t                state_d;
  logic                  do_wr;
  logic                  do_rd;
  logic                  wr_err_set;
  logic                  rd_err_set;
  logic                  wr_err_d;
  logic                  rd_err_d;

  // Unused and unknown codes collapse to NO_OP so the datapath never acts on garbage.
  function automatic state_t decode_code(input logic [2:0] code);
    state_t s;
    case (code)
      3'b000:  s = INIT;
      3'b001:  s = WRITE;
      3'b010:  s = READ;
      3'b011:  s = WR_ERROR;
      3'b100:  s = RD_ERROR;
      default: s = NO_OP;
    endcase
    return s;
  endfunction

  assign state = state_q;
  assign full  = (data_count == 4'd8);
  assign empty = (data_count == 4'd0);

  always_comb begin
    state_d    = decode_code(next_state);
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    wr_err_set = 1'b0;
    rd_err_set = 1'b0;
    case (state_d)
      WRITE:    if (full) wr_err_set = 1'b1; else do_wr = 1'b1;
      READ:     if (empty) rd_err_set = 1'b1; else do_rd = 1'b1;
      WR_ERROR: wr_err_set = 1'b1;
      RD_ERROR: rd_err_set = 1'b1;
      default:  ;
    endcase
`ifdef FIFO_STICKY_ERR_EN
    wr_err_d = wr_err_set | (wr_err & ~do_wr);
    rd_err_d = rd_err_set | (rd_err & ~do_rd);
`else
    wr_err_d = wr_err_set;
    rd_err_d = rd_err_set;
`endif
  end

  // Control, pointers, count and status: cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      head       <= 3'd0;
      tail       <= 3'd0;
      data_count <= 4'd0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ack  <= do_wr;
      rd_ack  <= do_rd;
      wr_err  <= wr_err_d;
      rd_err  <= rd_err_d;
      if (do_wr) begin
        tail       <= tail + 3'd1;
        data_count <= data_count + 4'd1;
      end else if (do_rd) begin
        head       <= head + 3'd1;
        data_count <= data_count - 4'd1;
        dout       <= mem[head];
      end
    end
  end

  // Storage keeps its contents across reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem[tail] <= din;
    end
  end

endmodule

// File: doc/fifo_datapath.md
FIFO_DATAPATH -- requirements
Module: fifo_datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of din/dout and of each storage entry.
REQ-002 Port clk  input  1  single clock; all registers update on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port next_state  input  3  next-state code from the FIFO next-state logic; INIT=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100, NO_OP=101.
REQ-005 Port din  input  DATA_WIDTH  write data, sampled on the edge that performs a write.
REQ-006 Port state  output  3  registered current state, fed back to the next-state logic.
REQ-007 Port data_count  output  4  number of stored entries, range 0..8.
REQ-008 Port dout  output  DATA_WIDTH  registered read data.
REQ-009 Port full / empty  output  1 each  full = (data_count==8); empty = (data_count==0); combinational from data_count.
REQ-010 Port wr_ack / wr_err / rd_ack / rd_err  output  1 each  registered per-edge handshake status.

Function
REQ-011 Storage SHALL be 8 entries x DATA_WIDTH; head (read) and tail (write) pointers SHALL be 3 bits and wrap 7->0.
REQ-012 Each rising edge SHALL load state <= next_state; codes 110/111 or X SHALL load NO_OP.
REQ-013 next_state==WRITE with data_count<8: mem[tail]<=din, tail<=tail+1, data_count<=data_count+1, wr_ack=1, all other status 0.
REQ-014 next_state==WRITE with data_count==8 (defensive): no storage or pointer change, wr_err=1, wr_ack=0.
REQ-015 next_state==READ with data_count>0: dout<=mem[head], head<=head+1, data_count<=data_count-1, rd_ack=1; dout valid the cycle after the edge (1-cycle latency).
REQ-016 next_state==READ with data_count==0 (defensive): no change, rd_err=1, rd_ack=0.
REQ-017 next_state==WR_ERROR: wr_err=1, no storage/pointer/count change; RD_ERROR: rd_err=1 likewise.
REQ-018 next_state INIT or NO_OP: all four status outputs 0, no storage/pointer/count change.
REQ-019 dout SHALL hold its last value on every edge that does not perform a successful read.
REQ-020 At most one of write/read SHALL occur per edge; data_count SHALL never exceed 8 nor underflow below 0.
REQ-021 Entries SHALL be read in exact write order across pointer wrap-around.

Reset
REQ-022 reset high SHALL immediately force state=INIT, head=0, tail=0, data_count=0, dout=0, wr_ack=wr_err=rd_ack=rd_err=0, giving empty=1, full=0.
REQ-023 Storage contents SHALL NOT be cleared by reset.
REQ-024 reset asserted mid-operation SHALL abort any operation in progress; first edge after deassertion SHALL be handled per REQ-012..REQ-018.

Configuration
REQ-025 Macro FIFO_STICKY_ERR_EN defined: wr_err SHALL stay 1 from its setting edge until the next successful write or reset; rd_err SHALL stay 1 until the next successful read or reset.
REQ-026 Macro FIFO_STICKY_ERR_EN undefined: wr_err/rd_err SHALL be single-edge pulses per REQ-014, REQ-016, REQ-017.

Verification
REQ-027 Reset then next_state=NO_OP for 3 cycles -> state=101, data_count=0, empty=1, full=0, all status 0.
REQ-028 8 WRITEs of din=0x11..0x88 -> wr_ack=1 each cycle, data_count 1..8, full=1 after 8th; 9th edge WR_ERROR -> wr_err=1, data_count=8.
REQ-029 From full, 8 READs -> dout=0x11..0x88 in order, one cycle after each edge, rd_ack=1; then RD_ERROR -> rd_err=1, empty=1, dout holds 0x88.
REQ-030 Wrap: write 6, read 6, write 5, read 5 -> data returned in order, pointers wrap, data_count ends 0.
REQ-031 Assert reset while data_count=5 mid-write -> state=INIT, data_count=0, empty=1 immediately, before the next clock edge.
REQ-032 With FIFO_STICKY_ERR_EN: RD_ERROR then 2 NO_OP -> rd_err stays 1; then WRITE, READ -> rd_err clears on the READ edge; without macro, rd_err=0 after first NO_OP.
